// File: rtl/seq_mem_pkg.sv
// seq_mem_pkg
// Shared definitions for the sequential memory arbiter slice:
//   state_t     - arbiter FSM states
//   REQ_FETCH   - requester id / grant bit index of the fetch stage
//   REQ_DATA    - requester id / grant bit index of the data stage
//   DEF_ADDR_W  - default word-address width of the data memory
//   DEF_LAT     - default memory read latency in cycles
package seq_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_DATA  = 1'b1;

  localparam int DEF_ADDR_W = 11;
  localparam int DEF_LAT    = 2;

endpackage

// File: rtl/seq_mem_grant.sv
// seq_mem_grant
// Picks one requester from the fetch and data request lines.
// Configuration macro: SEQ_MEM_ARB_RR_EN
//   undefined - fixed priority, data wins a tie, no pointer input
//   defined   - round robin, a tie goes to the requester not granted last
// Ports:
//   f_req     in   fetch request
//   d_req     in   data request
//   last_data in   (RR build only) 1 = data was granted last
//   grant     out  one-hot grant, indexed by REQ_FETCH / REQ_DATA
module seq_mem_grant
  import seq_mem_pkg::*;
(
  input  logic       f_req,
  input  logic       d_req,
`ifdef SEQ_MEM_ARB_RR_EN
  input  logic       last_data,
`endif
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (f_req && d_req) begin
`ifdef SEQ_MEM_ARB_RR_EN
      // Reset value of the pointer means "fetch last", so data wins the first tie.
      if (last_data) grant[REQ_FETCH] = 1'b1;
      else           grant[REQ_DATA]  = 1'b1;
`else
      grant[REQ_DATA] = 1'b1;
`endif
    end else if (d_req) begin
      grant[REQ_DATA] = 1'b1;
    end else if (f_req) begin
      grant[REQ_FETCH] = 1'b1;
    end
  end

endmodule

// File: rtl/seq_mem_arbiter.sv
// seq_mem_arbiter
// Shares one single-port data memory between the fetch stage and the data
// stage of a sequential processor. One access in flight at a time:
//   IDLE -> ISSUE (m_en) -> WAIT (LAT cycles) -> RESP (ack) -> IDLE
//   IDLE -> RESP directly when the address is out of range.
// Configuration macro: SEQ_MEM_ARB_RR_EN (round-robin tie break; default is
// fixed data-over-fetch priority).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   f_req/f_addr                  fetch request and word address
//   f_ack/f_rdata/f_err           fetch completion pulse, data, address error
//   d_req/d_we/d_addr/d_wdata     data-stage request
//   d_ack/d_rdata/d_err           data completion pulse, data, address error
//   m_en/m_we/m_addr/m_wdata      memory strobe, write enable, address, data
//   m_rdata                       memory read data, valid LAT cycles after m_en
//   busy                          high whenever the FSM is not IDLE
module seq_mem_arbiter
  import seq_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LAT    = DEF_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [63:0]       f_addr,
  output logic              f_ack,
  output logic [63:0]       f_rdata,
  output logic              f_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [63:0]       d_addr,
  input  logic [63:0]       d_wdata,
  output logic              d_ack,
  output logic [63:0]       d_rdata,
  output logic              d_err,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [63:0]       m_wdata,
  input  logic [63:0]       m_rdata,
  output logic              busy
);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q;
  logic                gnt_id_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [63:0]         wdata_q;
  logic [63:0]         rdata_q;
  logic                err_q;

  logic [1:0]          grant;
  logic                any_req;
  logic                sel_id;
  logic [63:0]         sel_addr;
  logic                sel_we;
  logic                sel_err;

`ifdef SEQ_MEM_ARB_RR_EN
  logic                last_data_q;
`endif

  seq_mem_grant u_grant (
    .f_req     (f_req),
    .d_req     (d_req),
`ifdef SEQ_MEM_ARB_RR_EN
    .last_data (last_data_q),
`endif
    .grant     (grant)
  );

  assign any_req  = f_req | d_req;
  assign sel_id   = grant[REQ_DATA] ? REQ_DATA : REQ_FETCH;
  assign sel_addr = (sel_id == REQ_DATA) ? d_addr : f_addr;
  assign sel_we   = (sel_id == REQ_DATA) & d_we;
  // Any bit above the memory's word range makes the address illegal.
  assign sel_err  = |sel_addr[63:ADDR_W];

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    m_en    = 1'b0;
    m_we    = 1'b0;
    f_ack   = 1'b0;
    d_ack   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (any_req) state_d = sel_err ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        m_en    = 1'b1;
        m_we    = we_q;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == 4'(LAT)) state_d = ST_RESP;
      end
      ST_RESP: begin
        f_ack   = (gnt_id_q == REQ_FETCH);
        d_ack   = (gnt_id_q == REQ_DATA);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request fields are frozen at the grant edge so the requester's later
  // changes cannot disturb the access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      gnt_id_q <= REQ_FETCH;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            gnt_id_q <= sel_id;
            we_q     <= sel_we;
            addr_q   <= sel_addr[ADDR_W-1:0];
            wdata_q  <= (sel_id == REQ_DATA) ? d_wdata : 64'd0;
            err_q    <= sel_err;
            rdata_q  <= '0;
            cnt_q    <= '0;
          end
        end
        ST_ISSUE: cnt_q <= 4'd1;
        ST_WAIT: begin
          // cnt_q == LAT marks cycle ISSUE+LAT, the one carrying m_rdata.
          if (cnt_q == 4'(LAT)) rdata_q <= we_q ? 64'd0 : m_rdata;
          else                  cnt_q   <= cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef SEQ_MEM_ARB_RR_EN
  // Zero means "fetch granted last".
  always_ff @(posedge clk) begin
    if (rst)                              last_data_q <= 1'b0;
    else if (state_q == ST_IDLE && any_req) last_data_q <= sel_id;
  end
`endif

  assign m_addr  = m_en  ? addr_q  : '0;
  assign m_wdata = m_en  ? wdata_q : '0;
  assign f_rdata = f_ack ? rdata_q : '0;
  assign f_err   = f_ack & err_q;
  assign d_rdata = d_ack ? rdata_q : '0;
  assign d_err   = d_ack & err_q;

endmodule

// File: tb/tb_seq_mem_arbiter.sv
// tb_seq_mem_arbiter
// Directed bench for seq_mem_arbiter. A memory with LAT-cycle read latency
// sits behind the DUT; a transaction-level model (grant rule, completion
// cycle, reference memory) predicts every cycle's outputs.
// Honours SEQ_MEM_ARB_RR_EN the same way the design does.
module tb_seq_mem_arbiter;

  localparam int ADDR_W = 11;
  localparam int LAT    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              f_req;
  logic [63:0]       f_addr;
  logic              f_ack;
  logic [63:0]       f_rdata;
  logic              f_err;
  logic              d_req;
  logic              d_we;
  logic [63:0]       d_addr;
  logic [63:0]       d_wdata;
  logic              d_ack;
  logic [63:0]       d_rdata;
  logic              d_err;
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [63:0]       m_wdata;
  logic [63:0]       m_rdata;
  logic              busy;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  bit check_en = 1'b0;

  seq_mem_arbiter #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata), .f_err(f_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Environment memory: word i starts as i; reads return data LAT cycles
  // after the strobe cycle and a poison value at any other time.
  logic [63:0] mem    [0:2047];
  logic [63:0] pipe_d [LAT];
  logic        pipe_v [LAT];

  always @(posedge clk) begin
    if (rst && cyc < 3) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 64'(i);
      for (int i = 0; i < LAT; i++) begin pipe_v[i] <= 1'b0; pipe_d[i] <= '0; end
    end else begin
      if (m_en && m_we) mem[m_addr] <= m_wdata;
      pipe_v[0] <= m_en && !m_we;
      pipe_d[0] <= mem[m_addr];
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign m_rdata = pipe_v[LAT-1] ? pipe_d[LAT-1] : 64'hDEAD_BEEF_DEAD_BEEF;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Transaction-level model: on a grant it fixes which requester wins, when
  // the strobe and the ack fall, and what the ack returns.
  logic [63:0] ref_mem [0:2047];
  bit          active, e_data, e_we, e_err, rr_last_data;
  int          g_cyc, ack_cyc;
  logic [ADDR_W-1:0] e_addr;
  logic [63:0] e_wdata, e_rdata;

  initial begin : model
    int  c;
    bit  was_free, exp_men, exp_fack, exp_dack, pick_data;
    logic [63:0] a64;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 64'(i);
    active = 1'b0;
    rr_last_data = 1'b0;
    wait (check_en);
    forever begin
      @(negedge clk);
      c = cyc;
      exp_men  = active && !e_err && (c == g_cyc + 1);
      exp_fack = active && (c == ack_cyc) && !e_data;
      exp_dack = active && (c == ack_cyc) && e_data;
      checkOutput("busy", 64'(busy), 64'(active && c > g_cyc));
      checkOutput("m_en", 64'(m_en), 64'(exp_men));
      checkOutput("m_we", 64'(m_we), 64'(exp_men && e_we));
      if (exp_men) begin
        checkOutput("m_addr", 64'(m_addr), 64'(e_addr));
        if (e_we) checkOutput("m_wdata", m_wdata, e_wdata);
      end
      checkOutput("f_ack", 64'(f_ack), 64'(exp_fack));
      checkOutput("d_ack", 64'(d_ack), 64'(exp_dack));
      if (exp_fack) begin
        checkOutput("f_rdata", f_rdata, e_rdata);
        checkOutput("f_err", 64'(f_err), 64'(e_err));
      end
      if (exp_dack) begin
        checkOutput("d_rdata", d_rdata, e_rdata);
        checkOutput("d_err", 64'(d_err), 64'(e_err));
      end
      was_free = !active;
      if (active && c == ack_cyc) active = 1'b0;
      if (rst) begin
        active = 1'b0;
        rr_last_data = 1'b0;
      end else if (was_free && (f_req || d_req)) begin
        if (f_req && d_req) begin
`ifdef SEQ_MEM_ARB_RR_EN
          pick_data = !rr_last_data;
`else
          pick_data = 1'b1;
`endif
        end else begin
          pick_data = d_req;
        end
        rr_last_data = pick_data;
        a64     = pick_data ? d_addr : f_addr;
        e_data  = pick_data;
        e_we    = pick_data && d_we;
        e_wdata = d_wdata;
        e_err   = (a64 >> ADDR_W) != 0;
        e_addr  = a64[ADDR_W-1:0];
        g_cyc   = c;
        ack_cyc = e_err ? c + 1 : c + LAT + 2;
        e_rdata = (e_err || e_we) ? 64'd0 : ref_mem[e_addr];
        if (!e_err && e_we) ref_mem[e_addr] = d_wdata;
        active  = 1'b1;
      end
    end
  end

  // Acts as one requester: raise req, wait (bounded) for its ack, drop req
  // so it is low in the cycle after the ack.
  task automatic applyStimulus(input bit is_data, input bit we, input logic [63:0] addr,
                               input logic [63:0] wdata, output logic [63:0] rdata,
                               output bit err, output int start_cyc, output int ack_at);
    bit got = 1'b0;
    rdata = '0;
    err = 1'b0;
    ack_at = -1;
    @(posedge clk); #1;
    start_cyc = cyc;
    if (is_data) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      f_req = 1'b1; f_addr = addr;
    end
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (is_data ? d_ack : f_ack) begin
        got    = 1'b1;
        rdata  = is_data ? d_rdata : f_rdata;
        err    = is_data ? d_err : f_err;
        ack_at = cyc;
      end
    end
    if (!got) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL ack_timeout: no ack within 60 cycles, required one (data=%0d)", is_data);
    end
    @(posedge clk); #1;
    if (is_data) d_req = 1'b0;
    else         f_req = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [63:0] rd, rd_f;
    bit          er, er_f;
    int          s, a, s_f, a_f;

    rst = 1'b1;
    f_req = 1'b0; f_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    @(posedge clk); #1;
    check_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    checkOutput("reset_busy",    64'(busy),  64'd0);
    checkOutput("reset_m_en",    64'(m_en),  64'd0);
    checkOutput("reset_m_we",    64'(m_we),  64'd0);
    checkOutput("reset_acks",    64'({f_ack, d_ack, f_err, d_err}), 64'd0);
    checkOutput("reset_d_rdata", d_rdata, 64'd0);
    checkOutput("reset_f_rdata", f_rdata, 64'd0);

    $display("[TB] read word 5");
    applyStimulus(1'b1, 1'b0, 64'd5, 64'd0, rd, er, s, a);
    checkOutput("read5_data", rd, 64'd5);
    checkOutput("read5_err", 64'(er), 64'd0);
    checkOutput("read5_latency", 64'(a - s), 64'(LAT + 2));

    $display("[TB] write 10 then read back");
    applyStimulus(1'b1, 1'b1, 64'd10, 64'hABCD, rd, er, s, a);
    checkOutput("write10_rdata", rd, 64'd0);
    checkOutput("write10_err", 64'(er), 64'd0);
    checkOutput("write10_latency", 64'(a - s), 64'(LAT + 2));
    applyStimulus(1'b1, 1'b0, 64'd10, 64'd0, rd, er, s, a);
    checkOutput("read10_data", rd, 64'hABCD);

    $display("[TB] top word boundary");
    applyStimulus(1'b1, 1'b1, 64'd2047, 64'h1234_5678_9ABC_DEF0, rd, er, s, a);
    applyStimulus(1'b0, 1'b0, 64'd2047, 64'd0, rd, er, s, a);
    checkOutput("fetch2047_data", rd, 64'h1234_5678_9ABC_DEF0);
    checkOutput("fetch2047_err", 64'(er), 64'd0);

    $display("[TB] fetch read word 7");
    applyStimulus(1'b0, 1'b0, 64'd7, 64'd0, rd, er, s, a);
    checkOutput("fetch7_data", rd, 64'd7);
    checkOutput("fetch7_latency", 64'(a - s), 64'(LAT + 2));

    $display("[TB] first tie");
    fork
      applyStimulus(1'b1, 1'b0, 64'd5, 64'd0, rd, er, s, a);
      applyStimulus(1'b0, 1'b0, 64'd12, 64'd0, rd_f, er_f, s_f, a_f);
    join
    checkOutput("tie1_d_latency", 64'(a - s), 64'(LAT + 2));
    checkOutput("tie1_f_after_d", 64'(a_f - a), 64'(LAT + 3));
    checkOutput("tie1_d_data", rd, 64'd5);
    checkOutput("tie1_f_data", rd_f, 64'd12);

    $display("[TB] second tie after a data access");
    applyStimulus(1'b1, 1'b0, 64'd20, 64'd0, rd, er, s, a);
    checkOutput("read20_data", rd, 64'd20);
    fork
      applyStimulus(1'b1, 1'b0, 64'd21, 64'd0, rd, er, s, a);
      applyStimulus(1'b0, 1'b0, 64'd22, 64'd0, rd_f, er_f, s_f, a_f);
    join
`ifdef SEQ_MEM_ARB_RR_EN
    checkOutput("tie2_fetch_first", 64'(a_f < a), 64'd1);
`else
    checkOutput("tie2_fetch_first", 64'(a_f < a), 64'd0);
`endif
    checkOutput("tie2_d_data", rd, 64'd21);
    checkOutput("tie2_f_data", rd_f, 64'd22);

    $display("[TB] address errors");
    applyStimulus(1'b1, 1'b0, 64'h800, 64'd0, rd, er, s, a);
    checkOutput("err800_err", 64'(er), 64'd1);
    checkOutput("err800_rdata", rd, 64'd0);
    checkOutput("err800_latency", 64'(a - s), 64'd1);
    applyStimulus(1'b1, 1'b1, 64'h803, 64'hFFFF, rd, er, s, a);
    checkOutput("err803_write_err", 64'(er), 64'd1);
    applyStimulus(1'b1, 1'b0, 64'd3, 64'd0, rd, er, s, a);
    checkOutput("word3_unchanged", rd, 64'd3);
    applyStimulus(1'b0, 1'b0, 64'h0000_0100_0000_0000, 64'd0, rd, er, s, a);
    checkOutput("fetch_hi_err", 64'(er), 64'd1);
    checkOutput("fetch_hi_rdata", rd, 64'd0);

    $display("[TB] reset during WAIT");
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'd5;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; d_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("rst_wait_busy", 64'(busy), 64'd0);
    checkOutput("rst_wait_ack", 64'(d_ack), 64'd0);
    repeat (LAT + 3) @(posedge clk);
    applyStimulus(1'b1, 1'b0, 64'd10, 64'd0, rd, er, s, a);
    checkOutput("after_rst_data", rd, 64'hABCD);
    checkOutput("after_rst_latency", 64'(a - s), 64'(LAT + 2));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
